// File: rtl/usr_datapath_if.sv
// Command/status bundle between the USR control FSM (master) and the shift datapath (slave).
interface usr_datapath_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       S;
  logic [WIDTH-1:0] L;
  logic [1:0]       count;
  logic [WIDTH-1:0] Q;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, S, L, count,
    input  cmd_ready, Q, carry, ovf, zero, busy, done
  );

  modport slave (
    input  cmd_valid, S, L, count,
    output cmd_ready, Q, carry, ovf, zero, busy, done
  );
endinterface

// File: rtl/usr_datapath.sv
// Universal shift register datapath: accepts one op per handshake, shifts one bit per clock,
// then pulses done with carry/ovf status held until the next acceptance.
module usr_datapath #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  usr_datapath_if.slave  bus
);
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_CSR  = 3'b001;
  localparam logic [2:0] OP_CSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_LSL  = 3'b100;
  localparam logic [2:0] OP_ASR  = 3'b101;
  localparam logic [2:0] OP_ASL  = 3'b110;
  localparam logic [2:0] OP_LOAD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] step_q;
  logic             step_c;

  always_comb begin
    step_q = q_q;
    step_c = 1'b0;
    case (op_q)
      OP_CSR: begin step_q = {q_q[0], q_q[MSB:1]};      step_c = q_q[0];   end
      OP_CSL: begin step_q = {q_q[MSB-1:0], q_q[MSB]};  step_c = q_q[MSB]; end
      OP_LSR: begin step_q = {1'b0, q_q[MSB:1]};        step_c = q_q[0];   end
      OP_LSL: begin step_q = {q_q[MSB-1:0], 1'b0};      step_c = q_q[MSB]; end
      OP_ASR: begin step_q = {q_q[MSB], q_q[MSB:1]};    step_c = q_q[0];   end
      OP_ASL: begin step_q = {q_q[MSB-1:0], 1'b0};      step_c = q_q[MSB]; end
      default: begin step_q = q_q;                       step_c = 1'b0;     end
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    q_d     = q_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.S;
          rem_d   = bus.count;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          if (bus.S == OP_LOAD) begin
            q_d     = bus.L;
            state_d = ST_DONE;
          end else if (bus.S == OP_HOLD || bus.count == 2'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        q_d     = step_q;
        carry_d = step_c;
        // Sign change is judged on the value before this step; once set it sticks.
        if (op_q == OP_ASL && (q_q[MSB] != q_q[MSB-1]))
          ovf_d = 1'b1;
        rem_d = rem_q - 2'd1;
        if (rem_q == 2'd1)
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= 3'b000;
      rem_q   <= 2'd0;
      q_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.Q         = q_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = (q_q == '0);
endmodule

// File: tb/tb_usr_datapath.sv
// Scoreboard bench for usr_datapath: the driver pushes expected completions, a negedge
// monitor pops them whenever done is seen.
module tb_usr_datapath;
  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_mis;
  int   last_acc;
  bit   started;

  typedef struct {
    logic [3:0] q;
    logic       c;
    logic       o;
    int         at;
  } exp_t;
  exp_t sb[$];

  usr_datapath_if #(.WIDTH(4)) bus ();
  usr_datapath #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("busy_vs_ready", {31'd0, bus.busy}, {31'd0, ~bus.cmd_ready});
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_Q",     {28'd0, bus.Q},     {28'd0, e.q});
          chk("done_carry", {31'd0, bus.carry}, {31'd0, e.c});
          chk("done_ovf",   {31'd0, bus.ovf},   {31'd0, e.o});
          chk("done_zero",  {31'd0, bus.zero},  {31'd0, (e.q == 4'd0)});
          chk("done_cycle", cyc,                e.at);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] s, input logic [3:0] l, input logic [1:0] n,
                       input bit push, input logic [3:0] eq, input bit ec, input bit eo,
                       input int lat, input int exp_acc);
    int waited;
    int acc;
    waited = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.S = s;
    bus.L = l;
    bus.count = n;
    while (bus.cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      chk("accept_timeout", 32'd1, 32'd0);
      bus.cmd_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (exp_acc >= 0) chk("accept_edge", acc, exp_acc);
    if (push) sb.push_back('{eq, ec, eo, acc + lat});
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.S = 3'($urandom);
    bus.L = 4'($urandom);
    bus.count = 2'($urandom);
    last_acc = acc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] csr_seq [3];
    int a1;
    int waited;
    n_cmp = 0;
    n_mis = 0;
    started = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.S = 3'd0;
    bus.L = 4'd0;
    bus.count = 2'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    started = 1'b1;
    chk("rst_Q",     {28'd0, bus.Q},         32'd0);
    chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_busy",  {31'd0, bus.busy},      32'd0);
    chk("rst_done",  {31'd0, bus.done},      32'd0);
    chk("rst_zero",  {31'd0, bus.zero},      32'd1);

    issue(3'b111, 4'b1011, 2'd0, 1, 4'b1011, 0, 0, 0, -1);

    csr_seq[0] = 4'b1101;
    csr_seq[1] = 4'b1110;
    csr_seq[2] = 4'b0111;
    issue(3'b001, 4'b0000, 2'd3, 1, 4'b0111, 0, 0, 3, -1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("csr_step_Q", {28'd0, bus.Q}, {28'd0, csr_seq[k]});
    end

    issue(3'b111, 4'b1000, 2'd0, 1, 4'b1000, 0, 0, 0, -1);
    issue(3'b101, 4'b0000, 2'd2, 1, 4'b1110, 0, 0, 2, -1);
    issue(3'b111, 4'b0100, 2'd0, 1, 4'b0100, 0, 0, 0, -1);
    issue(3'b110, 4'b0000, 2'd1, 1, 4'b1000, 0, 1, 1, -1);

    issue(3'b111, 4'b1001, 2'd0, 1, 4'b1001, 0, 0, 0, -1);
    issue(3'b010, 4'b0000, 2'd3, 1, 4'b1100, 0, 0, 3, -1);
    a1 = last_acc;
    issue(3'b100, 4'b0000, 2'd1, 1, 4'b1000, 1, 0, 1, a1 + 5);
    issue(3'b100, 4'b0000, 2'd0, 1, 4'b1000, 0, 0, 0, -1);
    issue(3'b000, 4'b0000, 2'd2, 1, 4'b1000, 0, 0, 0, -1);

    issue(3'b111, 4'b1111, 2'd0, 1, 4'b1111, 0, 0, 0, -1);
    issue(3'b011, 4'b0000, 2'd3, 0, 4'b0000, 0, 0, 0, -1);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_Q",     {28'd0, bus.Q},         32'd0);
    chk("abort_busy",  {31'd0, bus.busy},      32'd0);
    chk("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("abort_carry", {31'd0, bus.carry},     32'd0);
    chk("abort_zero",  {31'd0, bus.zero},      32'd1);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    repeat (4) @(negedge clk);

    issue(3'b111, 4'b0110, 2'd0, 1, 4'b0110, 0, 0, 0, -1);
    issue(3'b111, 4'b0000, 2'd0, 1, 4'b0000, 0, 0, 0, -1);

    waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_pending", sb.size(), 32'd0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
